div_remainder_ctrl: RTL

- Sequential restoring divider for the 32-bit ALU Part 3 datapath.
- Reads the value held in the Divisor register (its output bus) together with a dividend, then computes quotient and remainder one bit per clock.
- Combined 2*WIDTH remainder/quotient register; results held stable after completion; start/busy/done handshake towards the ALU control.

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_sub_step.sv | 41 ++++
 rtl/div_remainder_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the sequential restoring
//               divider (div_remainder_ctrl) and its iteration step.
//               - state_t            : FSM state encoding
//               - DIV_WIDTH          : default operand width
//               - DIV_ZERO_QUOTIENT  : quotient reported on divide-by-zero
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Divide-by-zero reports an all-ones quotient (at the default width).
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = {DIV_WIDTH{1'b1}};

  // ST_FIX is only reachable when signed division is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sub_step.sv
`default_nettype none
// ============================================================================
// Module      : div_sub_step
// Description : One combinational restoring-division step.
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and keeps the difference only
//               when it is non-negative.
// Ports       : rem_hi     in  WIDTH  partial remainder before the shift
//               next_bit   in  1      dividend/quotient bit shifted in
//               divisor    in  WIDTH  divisor (magnitude)
//               rem_hi_out out WIDTH  partial remainder after the step
//               quo_bit    out 1      quotient bit produced by the step
// Revision    : 1.0 - initial release
// ============================================================================
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_hi,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_hi_out,
  output logic             quo_bit
);

  // The bit shifted out of the top of rem_hi is kept: with divisors at or
  // above 2^(WIDTH-1) the shifted remainder can exceed WIDTH bits, and the
  // trial subtraction must see it or the compare would be wrong.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted    = {rem_hi, next_bit};
  assign diff       = {1'b0, shifted} - {2'b00, divisor};
  assign quo_bit    = ~diff[WIDTH+1];
  // On success the result is below the divisor, so WIDTH bits suffice;
  // on failure (restore) the shifted value was below the divisor as well.
  assign rem_hi_out = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : div_sub_step
`default_nettype wire

// File: rtl/div_remainder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_remainder_ctrl
// Description : Sequential restoring divider, one quotient bit per clock.
//               A 2*WIDTH {remainder, quotient} register is shifted through
//               div_sub_step; results are held until the next division.
//               Build option: define SIGNED_DIV_EN for two's-complement
//               operands (adds a one-cycle sign FIX state).
// Ports       : clk          in  1      rising-edge clock
//               rst          in  1      asynchronous active-high reset
//               start        in  1      request, sampled only in IDLE
//               dividend     in  WIDTH  dividend, sampled on acceptance
//               divisor_val  in  WIDTH  Divisor register output
//               busy         out 1      division in progress (incl. DONE)
//               done         out 1      one-cycle result-valid pulse
//               div_zero     out 1      last divisor was zero
//               quotient     out WIDTH  last quotient (held)
//               remainder    out WIDTH  last remainder (held)
// Revision    : 1.0 - initial release
// ============================================================================
module div_remainder_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_val,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;          // {rem_hi, quo}
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;

  logic [WIDTH-1:0]     dividend_ld;
  logic [WIDTH-1:0]     divisor_ld;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_bit;
  logic [2*WIDTH-1:0]   rem_next;

`ifdef SIGNED_DIV_EN
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  // Iterate on magnitudes; the most-negative value maps onto itself, which
  // read as unsigned is exactly its magnitude.
  assign dividend_ld = dividend[WIDTH-1]    ? -dividend    : dividend;
  assign divisor_ld  = divisor_val[WIDTH-1] ? -divisor_val : divisor_val;
`else
  assign dividend_ld = dividend;
  assign divisor_ld  = divisor_val;
`endif

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_hi     (rem_q[2*WIDTH-1:WIDTH]),
    .next_bit   (rem_q[WIDTH-1]),
    .divisor    (divisor_q),
    .rem_hi_out (step_rem),
    .quo_bit    (step_bit)
  );

  // Shift the quotient half left, retiring its MSB into the step, and drop
  // the new quotient bit into the LSB.
  assign rem_next = {step_rem, rem_q[WIDTH-2:0], step_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SIGNED_DIV_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef SIGNED_DIV_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef SIGNED_DIV_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          divisor_d  = divisor_ld;
          rem_d      = {{WIDTH{1'b0}}, dividend_ld};
          cnt_d      = CNT_W'(WIDTH);
          div_zero_d = 1'b0;
`ifdef SIGNED_DIV_EN
          neg_quo_d  = dividend[WIDTH-1] ^ divisor_val[WIDTH-1];
          neg_rem_d  = dividend[WIDTH-1];
`endif
          if (divisor_val == '0) begin
            // Results are known immediately; skip straight to DONE.
            state_d     = ST_DONE;
            div_zero_d  = 1'b1;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
          end else begin
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        rem_d = rem_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
          state_d = ST_FIX;
`else
          state_d     = ST_DONE;
          quotient_d  = rem_next[WIDTH-1:0];
          remainder_d = rem_next[2*WIDTH-1:WIDTH];
`endif
        end
      end

`ifdef SIGNED_DIV_EN
      ST_FIX: begin
        // Quotient sign follows the operand signs; remainder follows the
        // dividend (truncating division).
        quotient_d  = neg_quo_q ? -rem_q[WIDTH-1:0]       : rem_q[WIDTH-1:0];
        remainder_d = neg_rem_q ? -rem_q[2*WIDTH-1:WIDTH] : rem_q[2*WIDTH-1:WIDTH];
        state_d     = ST_DONE;
      end
`endif

      ST_DONE: begin
        // start is deliberately not sampled here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign div_zero  = div_zero_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule : div_remainder_ctrl
`default_nettype wire
